decoder_138: RTL and testbench
==============================

DECODER_138 -- requirements
Module: decoder_138

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 1; 1 = selected output line driven 0 and others 1; 0 = selected line driven 1 and others 0.
REQ-002 Port clk  input  1  rising-edge clock for the output register.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port A  input  1  select bit 0 (LSB).
REQ-005 Port B  input  1  select bit 1.
REQ-006 Port C  input  1  select bit 2 (MSB).
REQ-007 Port G1  input  1  enable, active-high.
REQ-008 Port G2An  input  1  enable, active-low.
REQ-009 Port G2Bn  input  1  enable, active-low.
REQ-010 Port Y  output  8  decoded lines; Y[i] corresponds to index i = {C,B,A}.
REQ-011 Port en_o  output  1  high when the decoder is enabled, aligned with Y.
REQ-012 The block SHALL have exactly one clock (clk) and one asynchronous, active-low reset (rst_n).

Function
REQ-013 The decoder SHALL be enabled only when G1=1, G2An=0 and G2Bn=0 simultaneously.
REQ-014 When enabled with OUT_ACTIVE_LOW=1, only Y[{C,B,A}] SHALL be 0 and all other bits 1.
REQ-015 When disabled with OUT_ACTIVE_LOW=1, Y SHALL be 8'hFF.
REQ-016 With OUT_ACTIVE_LOW=0, Y SHALL be the bitwise inverse of REQ-014/015: one-hot when enabled, 8'h00 when disabled.
REQ-017 en_o SHALL equal the enable condition of REQ-013.
REQ-018 Registered mode (see Configuration): Y and en_o SHALL update on each rising clk edge from the inputs sampled at that edge, with 1-cycle latency; no handshake, a new select is accepted every cycle.
REQ-019 Combinational mode: Y and en_o SHALL follow the inputs with zero cycles of latency.
REQ-020 Any change of a single enable SHALL take effect with the same latency as a select change; enable gating has priority over the select bits.
REQ-021 Behaviour SHALL be defined for 0/1 inputs only; the bench SHALL drive all inputs to known values outside reset.

Reset
REQ-022 In registered mode, rst_n=0 SHALL immediately, without a clock edge, force Y to the disabled pattern (8'hFF for OUT_ACTIVE_LOW=1, 8'h00 for OUT_ACTIVE_LOW=0) and en_o to 0.
REQ-023 In registered mode, Y and en_o SHALL hold their reset values while rst_n=0, and the first rising edge after release SHALL load the decoded inputs.
REQ-024 Reset asserted mid-operation SHALL discard the current output regardless of the inputs.
REQ-025 In combinational mode, rst_n SHALL have no effect on Y or en_o.

Configuration
REQ-026 Macro DECODER_138_REG_OUT_EN: when defined, the output register of REQ-018/022 SHALL be compiled in; when undefined, the outputs SHALL be purely combinational per REQ-019/025, with clk and rst_n kept as unused ports.

Verification
All scenarios use OUT_ACTIVE_LOW=1 and DECODER_138_REG_OUT_EN defined, except where stated.
REQ-027 Reset: rst_n=0 with G1=1, G2An=0, G2Bn=0, CBA=000 -> Y=8'hFF and en_o=0 at once, with no clk edge.
REQ-028 Sweep: enables active, CBA stepped 000..111 one per clock -> one cycle later Y = FE, FD, FB, F7, EF, DF, BF, 7F, with en_o=1.
REQ-029 Gating: CBA=011 with (G1=0), then (G2An=1), then (G2Bn=1) -> Y=8'hFF and en_o=0 after each edge.
REQ-030 Mid-sweep reset: rst_n pulsed low while CBA=101 -> Y=8'hFF immediately; first edge after release -> Y=8'hDF.
REQ-031 Combinational build, macro undefined: CBA=110 with enables active -> Y=8'hBF in the same timestep with no clock edge.
REQ-032 Polarity: OUT_ACTIVE_LOW=0, CBA=010 with enables active -> Y=8'h04; with decoder disabled -> Y=8'h00.

Source files
------------

// File: rtl/decoder_138.sv
// 3-to-8 line decoder with triple enable gating (one active-high, two active-low).
// Latency: 1 cycle when DECODER_138_REG_OUT_EN is defined, otherwise 0 (combinational).
// Backpressure: none; a new select/enable set is accepted every cycle.
//
// Configuration macro: DECODER_138_REG_OUT_EN
//   defined   -> Y/en_o come from an output register clocked by clk, cleared by rst_n
//   undefined -> Y/en_o are purely combinational; clk and rst_n are unused
//
// Ports:
//   clk        rising-edge clock for the output register
//   rst_n      asynchronous active-low reset (registered build only)
//   A, B, C    select bits, index = {C,B,A}
//   G1         enable, active-high
//   G2An, G2Bn enables, active-low
//   Y[7:0]     decoded lines; polarity set by OUT_ACTIVE_LOW
//   en_o       high when the decoder is enabled, aligned with Y
module decoder_138 #(
  parameter bit OUT_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       G1,
  input  logic       G2An,
  input  logic       G2Bn,
  output logic [7:0] Y,
  output logic       en_o
);

  logic       enable;
  logic [2:0] sel;
  logic [7:0] onehot;
  logic [7:0] y_next;

  assign enable = G1 & ~G2An & ~G2Bn;
  assign sel    = {C, B, A};

  // Enable gating wins over the select: a disabled decoder produces no hot bit at all.
  assign onehot = enable ? (8'd1 << sel) : 8'd0;
  assign y_next = OUT_ACTIVE_LOW ? ~onehot : onehot;

`ifdef DECODER_138_REG_OUT_EN
  // Disabled pattern, also the reset value of Y.
  localparam logic [7:0] Y_DISABLED = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y    <= Y_DISABLED;
      en_o <= 1'b0;
    end else begin
      Y    <= y_next;
      en_o <= enable;
    end
  end
`else
  assign Y    = y_next;
  assign en_o = enable;

  // clk and rst_n stay on the port list so both builds share one footprint.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_decoder_138.sv
module tb_decoder_138;

  logic       clk;
  logic       rst_n;
  logic       A, B, C;
  logic       G1, G2An, G2Bn;
  logic [7:0] y;
  logic       en_o;
  logic [7:0] y_p;
  logic       en_p;

  int checks;
  int fails;

  typedef struct {
    logic [7:0] y;
    logic       en;
    logic [7:0] yp;
    logic       enp;
  } exp_t;

  exp_t exp_q[$];

  decoder_138 #(.OUT_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
    .G1(G1), .G2An(G2An), .G2Bn(G2Bn), .Y(y), .en_o(en_o)
  );

  decoder_138 #(.OUT_ACTIVE_LOW(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
    .G1(G1), .G2An(G2An), .G2Bn(G2Bn), .Y(y_p), .en_o(en_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the selected line is worth 2**index; active-low output is
  // 255 minus that weight, active-high output is the weight itself.
  function automatic exp_t model(input bit g1, input bit g2a, input bit g2b, input int idx);
    exp_t e;
    int   hot;
    bit   on;
    on    = g1 && !g2a && !g2b;
    hot   = on ? (2 ** idx) : 0;
    e.y   = 8'(255 - hot);
    e.en  = on;
    e.yp  = 8'(hot);
    e.enp = on;
    return e;
  endfunction

  function automatic exp_t current_model();
    return model(G1, G2An, G2Bn, int'({C, B, A}));
  endfunction

  // What the outputs must show while rst_n is low.
  function automatic exp_t reset_exp();
    exp_t e;
`ifdef DECODER_138_REG_OUT_EN
    e.y   = 8'hFF;
    e.en  = 1'b0;
    e.yp  = 8'h00;
    e.enp = 1'b0;
`else
    e = current_model();
`endif
    return e;
  endfunction

  task automatic check_now(input string name, input exp_t e);
    chk({name, "_y"},    32'(y),    32'(e.y));
    chk({name, "_en"},   32'(en_o), 32'(e.en));
    chk({name, "_yp"},   32'(y_p),  32'(e.yp));
    chk({name, "_enp"},  32'(en_p), 32'(e.enp));
  endtask

  task automatic set_inputs(input bit g1, input bit g2a, input bit g2b, input logic [2:0] cba);
    G1   = g1;
    G2An = g2a;
    G2Bn = g2b;
    {C, B, A} = cba;
  endtask

  // Issue one vector between clock edges; its expected response goes to the scoreboard.
  task automatic drive(input bit g1, input bit g2a, input bit g2b, input logic [2:0] cba);
    @(negedge clk);
    set_inputs(g1, g2a, g2b, cba);
    exp_q.push_back(model(g1, g2a, g2b, int'(cba)));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: the registered build presents each vector after the next rising
  // edge; the combinational build already shows it then, so one sampling point serves both.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("scoreboard", e);
      end
    end
  end

  initial begin : stimulus
    checks = 0;
    fails  = 0;
    rst_n  = 1'b1;
    set_inputs(1'b1, 1'b0, 1'b0, 3'b000);

    // Reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_now("reset_async", reset_exp());

    // Outputs hold while reset stays low across clock edges.
    repeat (2) @(posedge clk);
    #1 check_now("reset_hold", reset_exp());
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep every select with the decoder enabled.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 3'(i));

    // Each enable alone disables the decoder.
    drive(1'b0, 1'b0, 1'b0, 3'b011);
    drive(1'b1, 1'b1, 1'b0, 3'b011);
    drive(1'b1, 1'b0, 1'b1, 3'b011);
    drive(1'b1, 1'b0, 1'b0, 3'b011);

    // Random vectors, biased so roughly half are enabled.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1, 0) == 1)
        drive(1'b1, 1'b0, 1'b0, 3'($urandom_range(7, 0)));
      else
        drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
    end
    drain("drain_random");

    // Reset pulse in the middle of operation with CBA=101.
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b0, 3'b101);
    #1 rst_n = 1'b0;
    #1 check_now("midreset_async", reset_exp());
    @(posedge clk);
    #1 check_now("midreset_hold", reset_exp());
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(1'b1, 1'b0, 1'b0, 5));
    drain("drain_midreset");

`ifndef DECODER_138_REG_OUT_EN
    // Combinational build: outputs follow inputs within the same timestep.
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b0, 3'b110);
    #1 chk("comb_y_110", 32'(y), 32'h0000_00BF);
    set_inputs(1'b1, 1'b0, 1'b0, 3'b010);
    #1 chk("comb_yp_010", 32'(y_p), 32'h0000_0004);
    set_inputs(1'b0, 1'b0, 1'b0, 3'b010);
    #1 chk("comb_yp_dis", 32'(y_p), 32'h0000_0000);
    rst_n = 1'b0;
    set_inputs(1'b1, 1'b0, 1'b0, 3'b001);
    #1 chk("comb_rst_ignored", 32'(y), 32'h0000_00FD);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
